s_axi_read_regbank: RTL and testbench

//  AXI4-Lite slave read responder for the DFX sequencer register space.

---
 rtl/dfx_seq_pkg.sv | 23 ++
 rtl/s_axi_read_decode.sv | 35 +++
 rtl/s_axi_read_regbank.sv | 127 ++++++++++++
 tb/tb_s_axi_read_regbank.sv | 212 +++++++++++++++++++++
 4 files changed

// File: rtl/dfx_seq_pkg.sv
// dfx_seq_pkg: shared constants for the DFX sequencer register space
//   bank-select codes, bank0 word indices, bank1 field codes, AXI RESP codes, read FSM states
package dfx_seq_pkg;
    localparam logic [1:0] BANK_SEL_0 = 2'b00;
    localparam logic [1:0] BANK_SEL_1 = 2'b01;
    localparam logic [1:0] B0_CONTROL = 2'd0;
    localparam logic [1:0] B0_STATUS  = 2'd1;
    localparam logic [1:0] B0_COUNTER = 2'd2;
    localparam logic [2:0] B1_SRC_ADDR = 3'd0;
    localparam logic [2:0] B1_SRC_SIZE = 3'd1;
    localparam logic [2:0] B1_DST_ADDR = 3'd2;
    localparam logic [2:0] B1_DST_SIZE = 3'd3;
    localparam logic [2:0] B1_STATUS   = 3'd4;
    localparam logic [2:0] B1_PROFILE  = 3'd5;
    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_CAPT,
        ST_RESP
    } state_t;
endpackage

// File: rtl/s_axi_read_decode.sv
// s_axi_read_decode: combinational AXI-Lite byte address -> register bank target
//   i_addr  : byte address; bits [1:0] and [ADDR_W-1:12] are don't-care (aliasing)
//   o_legal : address maps to an implemented register
//   o_bank  : 0 bank0, 1 bank1
//   o_idx   : bank0 word index
//   o_slot  : bank1 descriptor slot
//   o_field : bank1 descriptor field
module s_axi_read_decode
    import dfx_seq_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int IDX_W  = 3
) (
    input  logic [ADDR_W-1:0] i_addr,
    output logic              o_legal,
    output logic              o_bank,
    output logic [1:0]        o_idx,
    output logic [IDX_W-1:0]  o_slot,
    output logic [2:0]        o_field
);
    logic [1:0] w_sel;
    logic [4:0] w_hi;
    logic       w_unused;
    assign w_sel    = i_addr[11:10];
    // bank1 bits above the slot index must be zero; empty when IDX_W is 5
    assign w_hi     = i_addr[9:5] >> IDX_W;
    assign w_unused = ^{i_addr[ADDR_W-1:12], i_addr[1:0]};
    assign o_bank   = (w_sel == BANK_SEL_1);
    assign o_idx    = i_addr[3:2];
    assign o_slot   = i_addr[5 +: IDX_W];
    assign o_field  = i_addr[4:2];
    assign o_legal  = (w_sel == BANK_SEL_0) ? (i_addr[9:2] <= 8'(B0_COUNTER)) :
                      (w_sel == BANK_SEL_1) ? ((i_addr[4:2] <= B1_PROFILE) && (w_hi == 5'd0)) :
                      1'b0;
endmodule

// File: rtl/s_axi_read_regbank.sv
// s_axi_read_regbank: AXI4-Lite read slave for the DFX sequencer banks, one read in flight
//   clk, reset          : clock, asynchronous active-high reset
//   S_AXI_AR*/S_AXI_R*  : AXI4-Lite read address / read data channels
//   bank0_rd_*          : bank0 read strobe, word index, data (valid cycle after strobe)
//   bank1_rd_*          : bank1 read strobe, slot, field, data (valid cycle after strobe)
module s_axi_read_regbank
    import dfx_seq_pkg::*;
#(
    parameter int GLOB_ADDR_WIDTH   = 32,
    parameter int GLOB_DATA_WIDTH   = 32,
    parameter int BANK1_INDEX_WIDTH = 3
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic [GLOB_ADDR_WIDTH-1:0]   S_AXI_ARADDR,
    input  logic                         S_AXI_ARVALID,
    output logic                         S_AXI_ARREADY,
    output logic [GLOB_DATA_WIDTH-1:0]   S_AXI_RDATA,
    output logic [1:0]                   S_AXI_RRESP,
    output logic                         S_AXI_RVALID,
    input  logic                         S_AXI_RREADY,
    output logic                         bank0_rd_en,
    output logic [1:0]                   bank0_rd_idx,
    input  logic [GLOB_DATA_WIDTH-1:0]   bank0_rd_data,
    output logic                         bank1_rd_en,
    output logic [BANK1_INDEX_WIDTH-1:0] bank1_rd_slot,
    output logic [2:0]                   bank1_rd_field,
    input  logic [GLOB_DATA_WIDTH-1:0]   bank1_rd_data
);
    state_t                         r_state;
    logic                           r_arready;
    logic                           r_rvalid;
    logic [GLOB_DATA_WIDTH-1:0]     r_rdata;
    logic [1:0]                     r_rresp;
    logic                           r_bank;
    logic                           r_b0_en;
    logic                           r_b1_en;
    logic [1:0]                     r_idx;
    logic [BANK1_INDEX_WIDTH-1:0]   r_slot;
    logic [2:0]                     r_field;
    logic                           w_legal;
    logic                           w_bank;
    logic [1:0]                     w_idx;
    logic [BANK1_INDEX_WIDTH-1:0]   w_slot;
    logic [2:0]                     w_field;

    s_axi_read_decode #(
        .ADDR_W (GLOB_ADDR_WIDTH),
        .IDX_W  (BANK1_INDEX_WIDTH)
    ) u_decode (
        .i_addr  (S_AXI_ARADDR),
        .o_legal (w_legal),
        .o_bank  (w_bank),
        .o_idx   (w_idx),
        .o_slot  (w_slot),
        .o_field (w_field)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state   <= ST_IDLE;
            r_arready <= 1'b0;
            r_rvalid  <= 1'b0;
            r_rdata   <= '0;
            r_rresp   <= RESP_OKAY;
            r_bank    <= 1'b0;
            r_b0_en   <= 1'b0;
            r_b1_en   <= 1'b0;
            r_idx     <= '0;
            r_slot    <= '0;
            r_field   <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    r_arready <= 1'b1;
                    if (S_AXI_ARVALID && r_arready) begin
                        r_arready <= 1'b0;
                        r_bank    <= w_bank;
                        r_idx     <= w_idx;
                        r_slot    <= w_slot;
                        r_field   <= w_field;
                        if (w_legal) begin
                            r_state <= ST_ISSUE;
                            r_b0_en <= !w_bank;
                            r_b1_en <= w_bank;
                        end else begin
                            r_state  <= ST_RESP;
                            r_rdata  <= '0;
                            r_rresp  <= RESP_SLVERR;
                            r_rvalid <= 1'b1;
                        end
                    end
                end
                ST_ISSUE: begin
                    r_b0_en <= 1'b0;
                    r_b1_en <= 1'b0;
                    r_state <= ST_CAPT;
                end
                ST_CAPT: begin
                    r_rdata  <= r_bank ? bank1_rd_data : bank0_rd_data;
                    r_rresp  <= RESP_OKAY;
                    r_rvalid <= 1'b1;
                    r_state  <= ST_RESP;
                end
                ST_RESP: begin
                    // re-open the address channel in the same edge as the R handshake
                    if (S_AXI_RREADY) begin
                        r_rvalid  <= 1'b0;
                        r_arready <= 1'b1;
                        r_state   <= ST_IDLE;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign S_AXI_ARREADY  = r_arready;
    assign S_AXI_RVALID   = r_rvalid;
    assign S_AXI_RDATA    = r_rdata;
    assign S_AXI_RRESP    = r_rresp;
    assign bank0_rd_en    = r_b0_en;
    assign bank0_rd_idx   = r_idx;
    assign bank1_rd_en    = r_b1_en;
    assign bank1_rd_slot  = r_slot;
    assign bank1_rd_field = r_field;
endmodule

// File: tb/tb_s_axi_read_regbank.sv
// tb_s_axi_read_regbank: randomized self-checking bench for s_axi_read_regbank
module tb_s_axi_read_regbank;
    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] S_AXI_ARADDR;
    logic        S_AXI_ARVALID;
    logic        S_AXI_ARREADY;
    logic [31:0] S_AXI_RDATA;
    logic [1:0]  S_AXI_RRESP;
    logic        S_AXI_RVALID;
    logic        S_AXI_RREADY;
    logic        bank0_rd_en;
    logic [1:0]  bank0_rd_idx;
    logic [31:0] bank0_rd_data;
    logic        bank1_rd_en;
    logic [2:0]  bank1_rd_slot;
    logic [2:0]  bank1_rd_field;
    logic [31:0] bank1_rd_data;

    logic [31:0] mem0 [0:2];
    logic [31:0] mem1 [0:7][0:5];
    int n_chk = 0;
    int n_pass = 0;
    int n_b0 = 0;
    int n_b1 = 0;
    int n_both = 0;
    logic [1:0] s_idx;
    logic [2:0] s_slot;
    logic [2:0] s_field;

    s_axi_read_regbank #(
        .GLOB_ADDR_WIDTH   (32),
        .GLOB_DATA_WIDTH   (32),
        .BANK1_INDEX_WIDTH (3)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .S_AXI_ARADDR   (S_AXI_ARADDR),
        .S_AXI_ARVALID  (S_AXI_ARVALID),
        .S_AXI_ARREADY  (S_AXI_ARREADY),
        .S_AXI_RDATA    (S_AXI_RDATA),
        .S_AXI_RRESP    (S_AXI_RRESP),
        .S_AXI_RVALID   (S_AXI_RVALID),
        .S_AXI_RREADY   (S_AXI_RREADY),
        .bank0_rd_en    (bank0_rd_en),
        .bank0_rd_idx   (bank0_rd_idx),
        .bank0_rd_data  (bank0_rd_data),
        .bank1_rd_en    (bank1_rd_en),
        .bank1_rd_slot  (bank1_rd_slot),
        .bank1_rd_field (bank1_rd_field),
        .bank1_rd_data  (bank1_rd_data)
    );

    always #5 clk = ~clk;

    // bank storage: data valid the cycle after the strobe, noise otherwise
    always @(posedge clk) begin
        bank0_rd_data <= (bank0_rd_en && bank0_rd_idx < 2'd3) ? mem0[bank0_rd_idx] : $urandom;
        bank1_rd_data <= (bank1_rd_en && bank1_rd_field < 3'd6) ? mem1[bank1_rd_slot][bank1_rd_field] : $urandom;
    end

    always @(negedge clk) begin
        if (bank0_rd_en) begin
            n_b0  <= n_b0 + 1;
            s_idx <= bank0_rd_idx;
        end
        if (bank1_rd_en) begin
            n_b1    <= n_b1 + 1;
            s_slot  <= bank1_rd_slot;
            s_field <= bank1_rd_field;
        end
        if (bank0_rd_en && bank1_rd_en) n_both <= n_both + 1;
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    endtask

    // address map from the register-space rules, in plain arithmetic
    task automatic model(input logic [31:0] a, output bit legal, output bit bank,
                         output int idx, output int slot, output int field);
        int sel;
        sel   = (a >> 10) & 3;
        idx   = (a >> 2) & 255;
        slot  = (a >> 5) & 7;
        field = (a >> 2) & 7;
        bank  = (sel == 1);
        legal = (sel == 0) ? (idx < 3) : (sel == 1) ? (field < 6 && ((a >> 8) & 3) == 0) : 1'b0;
    endtask

    task automatic do_read(input logic [31:0] a, input int d, input bit pre, input bit hold);
        bit legal, bank;
        int idx, slot, field, k, b0, b1, bb;
        logic [31:0] ed;
        logic [1:0]  er;
        model(a, legal, bank, idx, slot, field);
        ed = !legal ? 32'd0 : bank ? mem1[slot][field] : mem0[idx];
        er = legal ? 2'b00 : 2'b10;
        b0 = n_b0;
        b1 = n_b1;
        bb = n_both;
        S_AXI_ARADDR  = a;
        S_AXI_ARVALID = 1'b1;
        S_AXI_RREADY  = pre;
        k = 0;
        while (!S_AXI_ARREADY && k < 10) begin
            @(negedge clk);
            k++;
        end
        if (!S_AXI_ARREADY) begin
            chk("arready_wait", S_AXI_ARREADY, 1);
            S_AXI_ARVALID = 1'b0;
            return;
        end
        @(negedge clk);
        if (!hold) S_AXI_ARVALID = 1'b0;
        k = 1;
        while (!S_AXI_RVALID && k < 20) begin
            @(negedge clk);
            k++;
        end
        chk("latency", k, legal ? 3 : 1);
        chk("arready_busy", S_AXI_ARREADY, 0);
        chk("rdata", S_AXI_RDATA, ed);
        chk("rresp", S_AXI_RRESP, er);
        if (!pre) begin
            repeat (d) begin
                @(negedge clk);
                chk("hold_rvalid", S_AXI_RVALID, 1);
                chk("hold_rdata", S_AXI_RDATA, ed);
                chk("hold_arready", S_AXI_ARREADY, 0);
            end
            S_AXI_RREADY = 1'b1;
        end
        @(negedge clk);
        S_AXI_RREADY = 1'b0;
        chk("rvalid_clr", S_AXI_RVALID, 0);
        chk("arready_ret", S_AXI_ARREADY, 1);
        chk("b0_pulses", n_b0 - b0, (legal && !bank) ? 1 : 0);
        chk("b1_pulses", n_b1 - b1, (legal && bank) ? 1 : 0);
        chk("both_pulses", n_both - bb, 0);
        if (legal && !bank) chk("b0_idx", s_idx, idx);
        if (legal && bank) begin
            chk("b1_slot", s_slot, slot);
            chk("b1_field", s_field, field);
        end
    endtask

    initial begin
        logic [31:0] base, a;
        int r;
        reset = 1'b1;
        S_AXI_ARADDR = '0;
        S_AXI_ARVALID = 1'b0;
        S_AXI_RREADY = 1'b0;
        for (int i = 0; i < 3; i++) mem0[i] = $urandom;
        for (int s = 0; s < 8; s++) for (int f = 0; f < 6; f++) mem1[s][f] = $urandom;
        mem0[1] = 32'h5;
        mem1[5][2] = 32'h1000_0000;
        repeat (3) @(negedge clk);
        chk("rst_arready", S_AXI_ARREADY, 0);
        chk("rst_rvalid", S_AXI_RVALID, 0);
        chk("rst_rdata", S_AXI_RDATA, 0);
        chk("rst_rresp", S_AXI_RRESP, 0);
        chk("rst_en", {bank0_rd_en, bank1_rd_en}, 0);
        reset = 1'b0;
        #1 chk("arready_pre_edge", S_AXI_ARREADY, 0);
        @(negedge clk);
        chk("arready_post_edge", S_AXI_ARREADY, 1);
        chk("idle_rvalid", S_AXI_RVALID, 0);
        do_read(32'h004, 0, 0, 0);
        do_read(32'h4A8, 1, 0, 0);
        do_read(32'h00C, 0, 0, 0);
        do_read(32'h4B8, 2, 0, 0);
        do_read(32'h800, 0, 1, 0);
        do_read(32'h008, 10, 0, 1);
        do_read(32'h008, 0, 0, 0);
        S_AXI_ARADDR = 32'h4A8;
        S_AXI_ARVALID = 1'b1;
        @(negedge clk);
        S_AXI_ARVALID = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        #1;
        chk("mid_arready", S_AXI_ARREADY, 0);
        chk("mid_rvalid", S_AXI_RVALID, 0);
        chk("mid_rdata", S_AXI_RDATA, 0);
        chk("mid_rresp", S_AXI_RRESP, 0);
        chk("mid_en", {bank0_rd_en, bank1_rd_en}, 0);
        chk("mid_sel", {bank0_rd_idx, bank1_rd_slot, bank1_rd_field}, 0);
        @(negedge clk);
        reset = 1'b0;
        repeat (5) begin
            @(negedge clk);
            chk("dropped_rvalid", S_AXI_RVALID, 0);
        end
        do_read(32'h4A8, 0, 0, 0);
        for (int n = 0; n < 150; n++) begin
            r = $urandom_range(0, 3);
            base = (r == 0) ? ($urandom_range(0, 4) << 2) :
                   (r == 1) ? ((32'd1 << 10) | (($urandom_range(0, 3) == 0 ? $urandom_range(1, 3) : 0) << 8) |
                               ($urandom_range(0, 7) << 5) | ($urandom_range(0, 7) << 2)) :
                   $urandom;
            a = (base & 32'h0000_0FFC) | ($urandom & 32'hFFFF_F003);
            do_read(a, $urandom_range(0, 3), $urandom_range(0, 3) == 0, 1'b0);
        end
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
